vga_timing_generator: RTL and testbench
=======================================

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 The block SHALL have one clock, VGA_CLOCK; reset RESET SHALL be synchronous and active-high.
REQ-002 The block SHALL expose these parameters:
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in clocks.
- H_SYNC, 96, hsync width in clocks.
- H_BACK, 48, horizontal back porch in clocks.
- V_VISIBLE, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, asserted sync level.
- PIXEL_LATENCY, 1, clocks from coordinate to PIXEL returned by the pixel source; legal range 0..4.
REQ-003 The block SHALL have these ports:
- VGA_CLOCK  in  1  pixel clock.
- RESET  in  1  synchronous active-high reset.
- PIXEL  in  3  colour from the pixel source: {red, green, blue}.
- PIXEL_H  out  11  current horizontal counter.
- PIXEL_V  out  11  current vertical counter.
- VGA_HSYNC  out  1  horizontal sync.
- VGA_VSYNC  out  1  vertical sync.
- VGA_RED  out  1  red output.
- VGA_GREEN  out  1  green output.
- VGA_BLUE  out  1  blue output.
- FRAME_START  out  1  one-clock pulse at start of each frame.

Function
REQ-004 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL be defined likewise; defaults give 800 and 525.
REQ-005 The horizontal counter SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-006 The vertical counter SHALL increment by 1 only on a horizontal wrap, and wrap from V_TOTAL-1 to 0 on the same clock the horizontal counter wraps.
REQ-007 PIXEL_H and PIXEL_V SHALL be driven directly from the counter registers with no added delay.
REQ-008 The raw active signal SHALL be true iff PIXEL_H < H_VISIBLE and PIXEL_V < V_VISIBLE.
REQ-009 Raw hsync SHALL be asserted iff H_VISIBLE+H_FRONT <= PIXEL_H < H_VISIBLE+H_FRONT+H_SYNC; defaults give 656..751.
REQ-010 Raw vsync SHALL be asserted iff V_VISIBLE+V_FRONT <= PIXEL_V < V_VISIBLE+V_FRONT+V_SYNC, for the full line duration; defaults give lines 490..491.
REQ-011 Raw active, hsync and vsync SHALL pass through a PIXEL_LATENCY-stage delay line and then one output register, for a total latency of PIXEL_LATENCY+1 clocks from the counter value.
REQ-012 On the clock edge when the delayed active is true, the RGB outputs SHALL load PIXEL bits 2, 1 and 0 respectively; otherwise they SHALL load 0 (forced blanking).
REQ-013 VGA_HSYNC and VGA_VSYNC SHALL output SYNC_POL when asserted and ~SYNC_POL when deasserted.
REQ-014 FRAME_START SHALL be registered and high for exactly the one clock in which the counters read (0,0) as a result of a wrap from (H_TOTAL-1, V_TOTAL-1).
REQ-015 FRAME_START SHALL NOT pulse for the (0,0) state immediately after reset release.
REQ-016 With PIXEL_LATENCY=0, the delay line SHALL be absent and latency SHALL be 1 clock.
REQ-017 Counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1, and 11 bits SHALL hold any legal total up to 2047.

Reset
REQ-018 While RESET is high, at each clock edge:
- both counters SHALL load 0;
- all delay-line stages SHALL load inactive and deasserted;
- RGB outputs SHALL be 0;
- sync outputs SHALL be ~SYNC_POL;
- FRAME_START SHALL be 0.
REQ-019 Reset asserted mid-frame SHALL take effect at the next edge.
REQ-020 The first clock after reset release SHALL present PIXEL_H=0 and PIXEL_V=0.

Verification
REQ-021 Release reset and hold PIXEL=3'b111 for 2 frames:
- exactly 420000 clocks between the two FRAME_START pulses;
- exactly 640x480 clocks with RGB=111 per frame.
REQ-022 Defaults, PIXEL_LATENCY=1: the first VGA_HSYNC low SHALL occur 2 clocks after PIXEL_H=656 and last 96 clocks; VGA_VSYNC low SHALL last 1600 clocks, starting 2 clocks after (0,490).
REQ-023 Drive PIXEL=3'b101 only when the coordinate delayed by 1 is (639,479); the next-cycle RGB SHALL equal 101, and RGB SHALL be 000 whenever PIXEL_H is in 640..799.
REQ-024 Assert RESET for 3 clocks at (400,200):
- outputs SHALL take reset values on the next edge;
- after release the counters SHALL restart at (0,0);
- FRAME_START SHALL stay low until the next full wrap.
REQ-025 Rerun REQ-022 with PIXEL_LATENCY=0 and with PIXEL_LATENCY=3; sync edges SHALL shift to 1 and 4 clocks respectively.
REQ-026 Rerun REQ-021 with SYNC_POL=1; sync waveforms SHALL be inverted and counts unchanged.

Source files
------------

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_generator
//  Purpose  : Free-running VGA raster timing. It produces the pixel
//             coordinates for an external pixel source, delays the derived
//             active/sync flags so they line up with that source's latency,
//             blanks RGB outside the visible area and flags each new frame.
//  Ports    : VGA_CLOCK    in   pixel clock
//             RESET        in   synchronous active-high reset
//             PIXEL[2:0]   in   {red, green, blue} from the pixel source
//             PIXEL_H[10:0]out  horizontal counter (undelayed)
//             PIXEL_V[10:0]out  vertical counter (undelayed)
//             VGA_HSYNC    out  horizontal sync, SYNC_POL when asserted
//             VGA_VSYNC    out  vertical sync, SYNC_POL when asserted
//             VGA_RED      out  red
//             VGA_GREEN    out  green
//             VGA_BLUE     out  blue
//             FRAME_START  out  one-clock pulse when the raster wraps to (0,0)
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
   parameter int unsigned H_VISIBLE     = 640,
   parameter int unsigned H_FRONT       = 16,
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_BACK        = 48,
   parameter int unsigned V_VISIBLE     = 480,
   parameter int unsigned V_FRONT       = 10,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_BACK        = 33,
   parameter logic        SYNC_POL      = 1'b0,
   parameter int unsigned PIXEL_LATENCY = 1     // legal range 0..4
) (
   input  logic        VGA_CLOCK,
   input  logic        RESET,
   input  logic [2:0]  PIXEL,
   output logic [10:0] PIXEL_H,
   output logic [10:0] PIXEL_V,
   output logic        VGA_HSYNC,
   output logic        VGA_VSYNC,
   output logic        VGA_RED,
   output logic        VGA_GREEN,
   output logic        VGA_BLUE,
   output logic        FRAME_START
);

   // ------------------------------------------------------------------------
   // Raster geometry, pre-sized to the 11-bit counter width
   // ------------------------------------------------------------------------
   localparam int unsigned c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] c_h_last     = 11'(c_h_total - 1);
   localparam logic [10:0] c_v_last     = 11'(c_v_total - 1);
   localparam logic [10:0] c_h_vis      = 11'(H_VISIBLE);
   localparam logic [10:0] c_v_vis      = 11'(V_VISIBLE);
   localparam logic [10:0] c_hs_start   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] c_hs_end     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] c_vs_start   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] c_vs_end     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   // ------------------------------------------------------------------------
   // Counters and frame marker
   // ------------------------------------------------------------------------
   logic [10:0] h_q, h_d;
   logic [10:0] v_q, v_d;
   logic        frame_q, frame_d;
   logic        h_last;
   logic        v_last;

   // ">=" rather than "==" keeps the counters bounded even if they were ever
   // disturbed past the last position.
   always_comb begin
      h_last  = (h_q >= c_h_last);
      v_last  = (v_q >= c_v_last);
      h_d     = h_last ? 11'd0 : h_q + 11'd1;
      v_d     = v_q;
      if (h_last) begin
         v_d = v_last ? 11'd0 : v_q + 11'd1;
      end
      // Registered so it is high exactly while the counters read (0,0)
      // after a genuine wrap; the post-reset (0,0) never sees this term.
      frame_d = h_last && v_last;
   end

   always_ff @(posedge VGA_CLOCK) begin
      if (RESET) begin
         h_q     <= 11'd0;
         v_q     <= 11'd0;
         frame_q <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
      end
   end

   // ------------------------------------------------------------------------
   // Raw raster flags, decoded from the live counters
   // ------------------------------------------------------------------------
   logic raw_act;
   logic raw_hs;
   logic raw_vs;

   always_comb begin
      raw_act = (h_q < c_h_vis) && (v_q < c_v_vis);
      raw_hs  = (h_q >= c_hs_start) && (h_q < c_hs_end);
      raw_vs  = (v_q >= c_vs_start) && (v_q < c_vs_end);
   end

   // ------------------------------------------------------------------------
   // Delay line matching the pixel source latency
   // ------------------------------------------------------------------------
   logic dly_act;
   logic dly_hs;
   logic dly_vs;

   generate
      if (PIXEL_LATENCY == 0) begin : g_no_delay
         assign dly_act = raw_act;
         assign dly_hs  = raw_hs;
         assign dly_vs  = raw_vs;
      end else begin : g_delay
         logic [PIXEL_LATENCY-1:0] act_q;
         logic [PIXEL_LATENCY-1:0] hs_q;
         logic [PIXEL_LATENCY-1:0] vs_q;

         always_ff @(posedge VGA_CLOCK) begin
            if (RESET) begin
               act_q <= '0;
               hs_q  <= '0;
               vs_q  <= '0;
            end else begin
               act_q[0] <= raw_act;
               hs_q[0]  <= raw_hs;
               vs_q[0]  <= raw_vs;
               for (int i = 1; i < PIXEL_LATENCY; i++) begin
                  act_q[i] <= act_q[i-1];
                  hs_q[i]  <= hs_q[i-1];
                  vs_q[i]  <= vs_q[i-1];
               end
            end
         end

         assign dly_act = act_q[PIXEL_LATENCY-1];
         assign dly_hs  = hs_q[PIXEL_LATENCY-1];
         assign dly_vs  = vs_q[PIXEL_LATENCY-1];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Output register: blanking and sync polarity applied here
   // ------------------------------------------------------------------------
   logic [2:0] rgb_q, rgb_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;

   always_comb begin
      rgb_d   = dly_act ? PIXEL : 3'b000;
      hsync_d = dly_hs ? SYNC_POL : ~SYNC_POL;
      vsync_d = dly_vs ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge VGA_CLOCK) begin
      if (RESET) begin
         rgb_q   <= 3'b000;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign PIXEL_H     = h_q;
   assign PIXEL_V     = v_q;
   assign VGA_HSYNC   = hsync_q;
   assign VGA_VSYNC   = vsync_q;
   assign VGA_RED     = rgb_q[2];
   assign VGA_GREEN   = rgb_q[1];
   assign VGA_BLUE    = rgb_q[0];
   assign FRAME_START = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_generator
//  Purpose  : Self-checking bench for vga_timing_generator. Four instances on
//             a reduced raster (32x17) share clock, reset and pixel input:
//             latency 0, 1, 3 with low-active sync and latency 2 with
//             high-active sync. A reference model derives every expected
//             output from the elapsed clock count since reset and pushes it
//             into per-instance queues; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

   localparam int HV = 16, HF = 4, HS = 6, HB = 6;
   localparam int VV = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int DEPTH = 16384;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  pix;
   logic [10:0] h  [4];
   logic [10:0] v  [4];
   logic        hs [4];
   logic        vs [4];
   logic        rr [4];
   logic        gg [4];
   logic        bb [4];
   logic        fs [4];

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_pix = 1'b0;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         vga_timing_generator #(
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
            .SYNC_POL((gi == 3) ? 1'b1 : 1'b0),
            .PIXEL_LATENCY((gi == 0) ? 0 : (gi == 1) ? 1 : (gi == 2) ? 3 : 2)
         ) u_dut (
            .VGA_CLOCK  (clk),
            .RESET      (rst),
            .PIXEL      (pix),
            .PIXEL_H    (h[gi]),
            .PIXEL_V    (v[gi]),
            .VGA_HSYNC  (hs[gi]),
            .VGA_VSYNC  (vs[gi]),
            .VGA_RED    (rr[gi]),
            .VGA_GREEN  (gg[gi]),
            .VGA_BLUE   (bb[gi]),
            .FRAME_START(fs[gi])
         );
      end
   endgenerate

   function automatic int lat_of(input int i);
      case (i)
         0:       return 0;
         1:       return 1;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic bit pol_of(input int i);
      return (i == 3);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: history of reset, elapsed count and pixel per edge
   // ------------------------------------------------------------------------
   int          n_h   [DEPTH];
   bit          rst_h [DEPTH];
   bit          mv_h  [DEPTH];
   logic [2:0]  pix_h [DEPTH];
   logic [27:0] sbq   [4][$];

   // Output seen after edge k: counters come from the elapsed count; sync and
   // RGB reflect the raster position L+1 edges earlier unless a reset edge
   // falls within the last L+1 edges; RGB takes the pixel sampled at edge k.
   function automatic logic [27:0] expect_out(input int L, input bit P, input int k);
      int  nc, np, hc, vc, hp, vp;
      bit  inact;
      logic hsx, vsx, fsx;
      logic [2:0] rgb;
      nc = n_h[k];
      hc = nc % HT;
      vc = (nc / HT) % VT;
      inact = 1'b0;
      for (int j = k - L; j <= k; j++) begin
         if (j < 0) inact = 1'b1;
         else if (!mv_h[j] || rst_h[j]) inact = 1'b1;
      end
      if (k - L - 1 < 0) inact = 1'b1;
      else if (!mv_h[k-L-1]) inact = 1'b1;
      hsx = ~P;
      vsx = ~P;
      rgb = 3'b000;
      if (!inact) begin
         np = n_h[k-L-1];
         hp = np % HT;
         vp = (np / HT) % VT;
         if (hp >= HV + HF && hp < HV + HF + HS) hsx = P;
         if (vp >= VV + VF && vp < VV + VF + VS) vsx = P;
         if (hp < HV && vp < VV) rgb = pix_h[k];
      end
      fsx = !rst_h[k] && (nc > 0) && (nc % FRAME == 0);
      return {11'(hc), 11'(vc), hsx, vsx, rgb, fsx};
   endfunction

   initial begin : model
      int  k;
      int  ncnt;
      bit  mvalid;
      k = 0; ncnt = 0; mvalid = 1'b0;
      forever begin
         @(posedge clk);
         if (k < DEPTH) begin
            if (rst) begin
               mvalid = 1'b1;
               ncnt   = 0;
            end else if (mvalid) begin
               ncnt++;
            end
            rst_h[k] = rst;
            n_h[k]   = ncnt;
            mv_h[k]  = mvalid;
            pix_h[k] = pix;
            if (mvalid) begin
               for (int i = 0; i < 4; i++) sbq[i].push_back(expect_out(lat_of(i), pol_of(i), k));
            end
            k++;
         end
      end
   end

   initial begin : monitor
      logic [27:0] e;
      logic [27:0] a;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (sbq[i].size() > 0) begin
               e = sbq[i].pop_front();
               a = {h[i], v[i], hs[i], vs[i], rr[i], gg[i], bb[i], fs[i]};
               check($sformatf("sb_u%0d", i), 32'(a), 32'(e));
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ------------------------------------------------------------------------
   task automatic step();
      @(negedge clk);
      if (rand_pix) pix = 3'($urandom);
   endtask

   task automatic wait_coord(input int th, input int tv, input string name);
      int cnt;
      bit found;
      cnt = 0;
      found = 1'b0;
      while (!found && cnt < 2 * FRAME) begin
         step();
         found = (int'(h[1]) == th) && (int'(v[1]) == tv);
         cnt++;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: coordinate (%0d,%0d) not reached", name, th, tv);
      end
   endtask

   task automatic wait_fs(output int cycles);
      cycles = 0;
      while (cycles < 2 * FRAME) begin
         step();
         cycles++;
         if (fs[1]) break;
      end
   endtask

   // From a raster position where the raw flag just rises, count clocks
   // until each instance's output asserts.
   task automatic measure_edge(input bit is_v, input string name);
      int first [4];
      logic s;
      for (int i = 0; i < 4; i++) first[i] = 0;
      for (int d = 1; d <= 6; d++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            s = is_v ? vs[i] : hs[i];
            if (first[i] == 0 && s == pol_of(i)) first[i] = d;
         end
      end
      for (int i = 0; i < 4; i++) check($sformatf("%s_u%0d", name, i), 32'(first[i]), 32'(lat_of(i) + 1));
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin : driver
      int cyc, per;
      int rgbc1, rgbc3, hl1, vl1, hh3, vh3;

      rst = 1'b1;
      pix = 3'b000;
      repeat (5) @(negedge clk);
      check("rst_state", 32'({h[1], v[1], hs[1], vs[1], rr[1], gg[1], bb[1], fs[1]}),
            32'({11'd0, 11'd0, 1'b1, 1'b1, 3'b000, 1'b0}));
      check("rst_pol1", 32'({hs[3], vs[3]}), 32'(2'b00));

      rst = 1'b0;
      pix = 3'b111;
      check("release_00", 32'({h[1], v[1]}), 32'd0);

      // Full-white frames: first pulse one full frame after release, then
      // frame period and per-frame counts of lit pixels and sync clocks.
      wait_fs(cyc);
      check("first_fs", 32'(cyc), 32'(FRAME));
      per = 0; rgbc1 = 0; rgbc3 = 0; hl1 = 0; vl1 = 0; hh3 = 0; vh3 = 0;
      do begin
         if ({rr[1], gg[1], bb[1]} == 3'b111) rgbc1++;
         if ({rr[3], gg[3], bb[3]} == 3'b111) rgbc3++;
         if (!hs[1]) hl1++;
         if (!vs[1]) vl1++;
         if (hs[3])  hh3++;
         if (vs[3])  vh3++;
         per++;
         step();
      end while (!fs[1] && per < 2 * FRAME);
      check("frame_period", 32'(per), 32'(FRAME));
      check("lit_u1", 32'(rgbc1), 32'(HV * VV));
      check("lit_u3", 32'(rgbc3), 32'(HV * VV));
      check("hs_low_u1", 32'(hl1), 32'(HS * VT));
      check("vs_low_u1", 32'(vl1), 32'(VS * HT));
      check("hs_high_u3", 32'(hh3), 32'(HS * VT));
      check("vs_high_u3", 32'(vh3), 32'(VS * HT));

      // Sync edge latency for each pipeline depth
      rand_pix = 1'b1;
      wait_coord(HV + HF, 1, "hs_coord");
      measure_edge(1'b0, "hs_edge");
      wait_coord(0, VV + VF, "vs_coord");
      measure_edge(1'b1, "vs_edge");

      // Single coloured pixel at the last visible position, as seen by the
      // latency-1 instance: drive it while the delayed coordinate is there.
      rand_pix = 1'b0;
      pix = 3'b000;
      wait_coord(HV - 1, VV - 1, "last_vis");
      step();
      pix = 3'b101;
      step();
      pix = 3'b000;
      check("rgb_101", 32'({rr[1], gg[1], bb[1]}), 32'(3'b101));

      // Mid-frame reset for three clocks
      rand_pix = 1'b1;
      wait_coord(20, 5, "mid_coord");
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst", 32'({h[1], v[1], hs[1], vs[1], rr[1], gg[1], bb[1], fs[1]}),
            32'({11'd0, 11'd0, 1'b1, 1'b1, 3'b000, 1'b0}));
      check("mid_rst_pol1", 32'({hs[3], vs[3]}), 32'(2'b00));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("restart_00", 32'({h[1], v[1]}), 32'd0);
      wait_fs(cyc);
      check("fs_after_rst", 32'(cyc), 32'(FRAME));

      repeat (FRAME / 2) step();
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
